// File: rtl/lkt_sched_pkg.sv
// lkt_pkg: shared widths, scheduler state encoding and select-vector check helper
package lkt_pkg;
  localparam int LKT_RESULT_WIDTH = 3;
  localparam int LKT_NUM_LOOKUPS  = 8;
  localparam int LKT_NUM_CHOICES  = 2;
  localparam int LKT_NUM_REQ      = 4;
  localparam int LKT_DP_LATENCY   = 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} lkt_sched_state_e;
  // A lookup's choice slice is legal only when exactly one choice is selected
  function automatic logic lkt_sel_onehot_ok(input logic [31:0] lane);
    return $countones(lane) == 1;
  endfunction
endpackage

// File: rtl/lkt_sched_if.sv
// lkt_sched_if: config write, request and response channels of the lkt scheduler
interface lkt_sched_if #(
  parameter int RESULT_WIDTH = 3,
  parameter int NUM_LOOKUPS  = 8,
  parameter int NUM_CHOICES  = 2,
  parameter int NUM_REQ      = 4
);
  logic                                        cfg_we;
  logic                                        cfg_ready;
  logic [$clog2(NUM_LOOKUPS*NUM_CHOICES)-1:0]  cfg_addr;
  logic [RESULT_WIDTH-1:0]                     cfg_data;
  logic [NUM_REQ-1:0]                          req_valid;
  logic [NUM_REQ-1:0]                          req_ready;
  logic [NUM_REQ*NUM_LOOKUPS*NUM_CHOICES-1:0]  req_sel;
  logic                                        rsp_valid;
  logic                                        rsp_ready;
  logic [$clog2(NUM_REQ)-1:0]                  rsp_id;
  logic [RESULT_WIDTH*NUM_LOOKUPS-1:0]         rsp_data;
  logic                                        rsp_err;
  modport master (
    output cfg_we, cfg_addr, cfg_data, req_valid, req_sel, rsp_ready,
    input  cfg_ready, req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, req_valid, req_sel, rsp_ready,
    output cfg_ready, req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/lkt_sched_rr_arb.sv
// lkt_rr_arb: round-robin pick starting at ptr, wrapping from NUM_REQ-1 to 0
module lkt_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);
  // Scan offsets from farthest to nearest so the requester closest to ptr wins
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NUM_REQ]) idx = $clog2(NUM_REQ)'((int'(ptr) + i) % NUM_REQ);
    gnt = (|req) ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/lkt_sched.sv
// lkt_sched: table owner, round-robin lookup scheduler and response returner (option: LKT_SCHED_SEL_CHECK_EN)
module lkt_sched
  import lkt_pkg::*;
#(
  parameter int RESULT_WIDTH = LKT_RESULT_WIDTH,
  parameter int NUM_LOOKUPS  = LKT_NUM_LOOKUPS,
  parameter int NUM_CHOICES  = LKT_NUM_CHOICES,
  parameter int NUM_REQ      = LKT_NUM_REQ,
  parameter int DP_LATENCY   = LKT_DP_LATENCY
) (
  input  logic                                             clk,
  input  logic                                             rst,
  lkt_sched_if.slave                                       bus,
  output logic [NUM_LOOKUPS*NUM_CHOICES*RESULT_WIDTH-1:0]  lookup_table_o,
  output logic [NUM_LOOKUPS*NUM_CHOICES-1:0]               input_o,
  input  logic [RESULT_WIDTH*NUM_LOOKUPS-1:0]              output_i
);
  localparam int NE = NUM_LOOKUPS * NUM_CHOICES;
  localparam int IW = $clog2(NUM_REQ);
  lkt_sched_state_e state, state_n;
  logic [IW-1:0] ptr, gid, idx;
  logic [NUM_REQ-1:0] gnt;
  logic [NE-1:0] sel_g;
  logic [3:0] cnt;
  logic [RESULT_WIDTH*NUM_LOOKUPS-1:0] rdata;
  logic gnt_en, sel_bad, err_q;
  lkt_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (.req(bus.req_valid), .ptr(ptr), .gnt(gnt), .idx(idx));
  assign sel_g = bus.req_sel[int'(idx)*NE +: NE];
`ifdef LKT_SCHED_SEL_CHECK_EN
  // Flag the grant when any lookup does not pick exactly one choice
  always_comb begin
    sel_bad = 1'b0;
    for (int l = 0; l < NUM_LOOKUPS; l++)
      if (!lkt_sel_onehot_ok(32'(sel_g[l*NUM_CHOICES +: NUM_CHOICES]))) sel_bad = 1'b1;
  end
`else
  assign sel_bad = 1'b0;
`endif
  assign bus.req_ready = gnt_en ? gnt : '0;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_id    = gid;
  assign bus.rsp_data  = rdata;
  assign bus.rsp_err   = err_q;
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  // Next state; a config write in IDLE blocks the grant for that cycle
  always_comb begin
    state_n       = state;
    gnt_en        = 1'b0;
    bus.cfg_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.cfg_ready = 1'b1;
        gnt_en        = !bus.cfg_we && (|bus.req_valid);
        state_n       = gnt_en ? (sel_bad ? RESP : WAIT) : IDLE;
      end
      WAIT:    state_n = (cnt == 4'd0) ? RESP : WAIT;
      RESP:    state_n = bus.rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // Table, issued select, latency counter, captured result and round-robin pointer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lookup_table_o <= '0;
      input_o        <= '0;
      rdata          <= '0;
      gid            <= '0;
      err_q          <= 1'b0;
      ptr            <= '0;
      cnt            <= '0;
    end else begin
      if (state == IDLE && bus.cfg_we) lookup_table_o[int'(bus.cfg_addr)*RESULT_WIDTH +: RESULT_WIDTH] <= bus.cfg_data;
      if (gnt_en) begin
        input_o <= sel_bad ? '0 : sel_g;
        gid     <= idx;
        cnt     <= 4'(DP_LATENCY);
        err_q   <= sel_bad;
        if (sel_bad) rdata <= '0;
      end
      if (state == WAIT) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd0) rdata <= output_i;
      end
      if (state == RESP && bus.rsp_ready) begin
        input_o <= '0;
        ptr     <= (int'(gid) == NUM_REQ - 1) ? '0 : gid + 1'b1;
      end
    end
endmodule

// File: tb/tb_lkt_sched.sv
// tb_lkt_sched: directed checks of table programming, round-robin, priority, backpressure and latency
module tb_lkt_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  lkt_sched_if bus ();
  lkt_sched_if bus0 ();
  logic [47:0] tab, tab0, et;
  logic [15:0] inp, inp0;
  logic [23:0] outp, outp0;
  int total = 0;
  int bad = 0;
  localparam logic [63:0] SA = 64'hAAAA5555AAAA5555;
  lkt_sched #(.DP_LATENCY(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave), .lookup_table_o(tab), .input_o(inp), .output_i(outp));
  lkt_sched #(.DP_LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave), .lookup_table_o(tab0), .input_o(inp0), .output_i(outp0));
  function automatic logic [23:0] dp(input logic [15:0] s, input logic [47:0] t);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[3*i +: 3] = s[2*i] ? t[6*i +: 3] : (s[2*i+1] ? t[6*i+3 +: 3] : 3'd0);
    return r;
  endfunction
  assign outp  = dp(inp, tab);
  assign outp0 = dp(inp0, tab0);
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_lookup(input logic [3:0] v, input logic [63:0] s, input int g, input logic [23:0] d,
                            input logic e, input int lat, input int hold);
    int n;
    logic [15:0] es;
    es = s[g*16 +: 16];
    bus.req_valid = v;
    bus.req_sel   = s;
    #1;
    chk("gnt", bus.req_ready, 64'(4'b0001 << g));
    tick();
    bus.req_valid = '0;
    chk("input_o", inp, e ? 16'h0 : es);
    n = 1;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", n, lat);
    chk("rsp_id", bus.rsp_id, g);
    chk("rsp_data", bus.rsp_data, d);
    chk("rsp_err", bus.rsp_err, e);
    bus.req_valid = (hold > 0) ? 4'hf : 4'h0;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_data", bus.rsp_data, d);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_cfg_ready", bus.cfg_ready, 0);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", bus.rsp_valid, 0);
  endtask
  initial begin
    int n, seen;
    {bus.cfg_we, bus.cfg_addr, bus.cfg_data, bus.req_valid, bus.req_sel, bus.rsp_ready} = '0;
    {bus0.cfg_we, bus0.cfg_addr, bus0.cfg_data, bus0.req_valid, bus0.req_sel, bus0.rsp_ready} = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_tab", tab, 0);
    chk("rst_input", inp, 0);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_id", bus.rsp_id, 0);
    chk("rst_data", bus.rsp_data, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_cfg_ready", bus.cfg_ready, 1);
    bus.cfg_we = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.cfg_addr = 4'(k);
      bus.cfg_data = 3'(k % 8);
      et[k*3 +: 3] = 3'(k % 8);
      tick();
    end
    bus.cfg_we = 1'b0;
    chk("table", tab, et);
    run_lookup(4'hf, SA, 0, 24'hD10D10, 1'b0, 5, 0);
    run_lookup(4'hf, SA, 1, 24'hF59F59, 1'b0, 5, 0);
    run_lookup(4'hf, SA, 2, 24'hD10D10, 1'b0, 5, 0);
    run_lookup(4'hf, SA, 3, 24'hF59F59, 1'b0, 5, 0);
    run_lookup(4'hf, SA, 0, 24'hD10D10, 1'b0, 5, 0);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 4'd4;
    bus.cfg_data  = 3'd7;
    bus.req_valid = 4'b0100;
    bus.req_sel   = SA;
    #1;
    chk("prio_no_gnt", bus.req_ready, 0);
    chk("prio_cfg_ready", bus.cfg_ready, 1);
    tick();
    bus.cfg_we = 1'b0;
    chk("prio_entry", tab[14:12], 7);
    run_lookup(4'b0100, SA, 2, 24'hD10DD0, 1'b0, 5, 0);
    run_lookup(4'b1000, SA, 3, 24'hF59F59, 1'b0, 5, 5);
`ifdef LKT_SCHED_SEL_CHECK_EN
    run_lookup(4'b0001, 64'hAAAA5555AAAA5557, 0, 24'h0, 1'b1, 1, 0);
    run_lookup(4'b0010, SA, 1, 24'hF59F59, 1'b0, 5, 0);
`endif
    bus0.cfg_we   = 1'b1;
    bus0.cfg_addr = 4'd0;
    bus0.cfg_data = 3'd5;
    tick();
    bus0.cfg_we    = 1'b0;
    bus0.req_valid = 4'b0001;
    bus0.req_sel   = 64'h5555;
    #1;
    chk("l0_gnt", bus0.req_ready, 4'b0001);
    tick();
    bus0.req_valid = '0;
    n = 1;
    while (!bus0.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("l0_latency", n, 2);
    chk("l0_data", bus0.rsp_data, 24'h5);
    bus0.rsp_ready = 1'b1;
    tick();
    bus0.rsp_ready = 1'b0;
    bus.req_valid = 4'hf;
    tick();
    bus.req_valid = '0;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_tab", tab, 0);
    chk("mid_rst_input", inp, 0);
    chk("mid_rst_cfg_ready", bus.cfg_ready, 1);
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen |= int'(bus.rsp_valid);
    end
    chk("mid_rst_no_rsp", seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lkt_sched.md
# lkt_sched

Scheduler and configuration controller for the lookup-table (lkt) datapath. It owns the lookup-table contents, which software programs through a write port. It arbitrates round-robin between `NUM_REQ` requesters, each presenting a per-lookup choice-select vector, and issues one lookup at a time to the shared datapath. After a fixed datapath latency it captures the result and returns it, tagged with the requester id, over a valid/ready response channel.

## Interface
Parameters:
- `RESULT_WIDTH`, 3: bits per table entry and per lookup result.
- `NUM_LOOKUPS`, 8: parallel lookups per request.
- `NUM_CHOICES`, 2: entries per lookup; select is one-hot per lookup.
- `NUM_REQ`, 4: requesters, ≥2.
- `DP_LATENCY`, 1: clocks from `input_o` driven to `output_i` valid, 0–15.

Ports:
- `clk`  in  1  clock. Everything is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cfg_we`  in  1  table write strobe.
- `cfg_ready`  out  1  write is accepted when `cfg_we & cfg_ready`.
- `cfg_addr`  in  $clog2(NUM_LOOKUPS*NUM_CHOICES)  entry index = lookup*NUM_CHOICES+choice.
- `cfg_data`  in  RESULT_WIDTH  entry value.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_ready`  out  NUM_REQ  one-hot grant, combinational.
- `req_sel`  in  NUM_REQ*NUM_LOOKUPS*NUM_CHOICES  select vector per requester; requester r occupies slice r.
- `lookup_table_o`  out  NUM_LOOKUPS*NUM_CHOICES*RESULT_WIDTH  table register to the datapath.
- `input_o`  out  NUM_LOOKUPS*NUM_CHOICES  registered select to the datapath.
- `output_i`  in  RESULT_WIDTH*NUM_LOOKUPS  datapath result.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  $clog2(NUM_REQ)  id of the granted requester.
- `rsp_data`  out  RESULT_WIDTH*NUM_LOOKUPS  captured result.
- `rsp_err`  out  1  illegal select flag (see Configuration).

## Operation
- FSM states are IDLE, WAIT and RESP. Reset enters IDLE.
- **IDLE**
  - `cfg_ready`=1.
  - If `cfg_we`=1: the entry is written and no grant is issued that cycle. Config write has priority.
  - Otherwise, if any `req_valid` is set: the round-robin arbiter raises `req_ready[g]`, latches `req_sel[g]` into `input_o`, records g, loads the counter with `DP_LATENCY`, and moves to WAIT.
- **WAIT**
  - `cfg_ready`=0.
  - The counter decrements each cycle.
  - When the counter is 0, `output_i` is captured into `rsp_data` and the FSM moves to RESP. With `DP_LATENCY`=0 this happens on the first WAIT cycle.
- **RESP**
  - `rsp_valid`=1, and `rsp_id`/`rsp_data`/`rsp_err` are held stable until `rsp_ready`.
  - On handshake: `input_o` clears to 0, the round-robin pointer moves to g+1 (mod `NUM_REQ`), and the FSM returns to IDLE.
- `req_ready` is 0 outside IDLE. A requester may deassert `req_valid` before it is granted without any side effect.
- Round-robin: the search starts at the pointer and wraps from `NUM_REQ-1` to 0. The pointer resets to 0.

## Timing
- Grant handshake at cycle T:
  - `input_o` is valid from T+1.
  - `output_i` is sampled at the edge ending cycle T+1+`DP_LATENCY`.
  - `rsp_valid` is high from T+2+`DP_LATENCY`.
- The earliest next grant is the cycle after the `rsp_ready` handshake. Back-to-back throughput is one lookup per `DP_LATENCY`+3 cycles.
- A table write accepted at cycle T appears on `lookup_table_o` at T+1.
- Reset values:
  - `lookup_table_o`, `input_o`, `rsp_data`, `rsp_id`, `rsp_err` = 0.
  - `rsp_valid`, `req_ready` = 0.
  - `cfg_ready`=1.
  - State = IDLE, pointer = 0.
- Reset asserted mid-WAIT or mid-RESP discards the lookup in flight, clears the table and returns to IDLE. No response is produced.

## Configuration
- Macro `LKT_SCHED_SEL_CHECK_EN`.
- **Defined:** at grant, each lookup's `NUM_CHOICES` slice of the selected vector is checked for exactly one bit set.
  - Any violation sets `rsp_err`=1 and `rsp_data`=0, leaves `input_o`=0, and moves directly to RESP, skipping WAIT.
  - The requester is consumed and the pointer advances as normal.
- **Undefined:** no check. `rsp_err` is tied 0 and every grant goes through WAIT.

## Structure
- Package `lkt_pkg` holds:
  - default width constants;
  - state enum `lkt_sched_state_e` {IDLE, WAIT, RESP};
  - function `lkt_sel_onehot_ok()`.
- Sub-module `lkt_rr_arb` (parameter `NUM_REQ`):
  - inputs: request vector, pointer;
  - outputs: one-hot grant and encoded index.
- Table storage, FSM and counter live in `lkt_sched`.

## Test plan
- **Table programming:** program all 16 entries with cfg_addr=k, cfg_data=k%8. Then requester 0 issues sel=16'h5555, choosing choice 0 in every lookup → rsp_id=0, rsp_data lane i = (2i)%8.
- **Round-robin:** all four req_valid held high → grants 0,1,2,3,0 in order, and each rsp_id matches its grant.
- **Config priority:** in IDLE, cfg_we and req_valid[2] in the same cycle → no grant that cycle; grant 2 next cycle, and the response uses the new entry.
- **Backpressure:** rsp_ready low for 5 cycles → rsp_valid/rsp_data stable, req_ready all 0, cfg_ready 0.
- **Latency:** DP_LATENCY=0 and DP_LATENCY=3 → rsp_valid first seen at T+2 and T+5 respectively.
- **Illegal select:** with `LKT_SCHED_SEL_CHECK_EN` defined, sel lane 0 = 2'b11 → rsp_err=1, rsp_data=0 at T+1, input_o stays 0.
